// File: rtl/midi_voice_scheduler.sv
// Turns decoded MIDI key events into ADPCM voice start/stop commands, issued one at a time
// over a valid/ready port (first command valid 2 cycles after the event; held while !ready).
// Optional MIDI_VOICE_SCHEDULER_RETRIGGER_EN: key_on on an active voice queues a stop before the start.
module midi_voice_scheduler #(
  parameter int CHANNELS = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] key_on,
  input  logic [CHANNELS-1:0] key_off,
  input  logic [3:0]          note,
  input  logic [1:0]          octave,
  output logic                voice_write_valid,
  input  logic                voice_write_ready,
  output logic [3:0]          voice_channel,
  output logic [1:0]          voice_cmd,
  output logic [15:0]         voice_pitch,
  input  logic [CHANNELS-1:0] voice_ended,
  output logic [CHANNELS-1:0] status_note_off,
  output logic                busy
);

  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;

`ifdef MIDI_VOICE_SCHEDULER_RETRIGGER_EN
  localparam logic RETRIG = 1'b1;
`else
  localparam logic RETRIG = 1'b0;
`endif

  typedef enum logic {IDLE, ISSUE} state_t;

  function automatic logic [15:0] base_pitch(input logic [3:0] n);
    case (n)
      4'd0:    base_pitch = 16'd4096;
      4'd1:    base_pitch = 16'd4340;
      4'd2:    base_pitch = 16'd4598;
      4'd3:    base_pitch = 16'd4871;
      4'd4:    base_pitch = 16'd5161;
      4'd5:    base_pitch = 16'd5468;
      4'd6:    base_pitch = 16'd5793;
      4'd7:    base_pitch = 16'd6137;
      4'd8:    base_pitch = 16'd6502;
      4'd9:    base_pitch = 16'd6889;
      4'd10:   base_pitch = 16'd7298;
      4'd11:   base_pitch = 16'd7732;
      default: base_pitch = 16'd0;
    endcase
  endfunction

  state_t                state, state_nx;
  logic [CHANNELS-1:0]   pend_on, pend_off, active;
  logic [CHANNELS-1:0]   pend_on_nx, pend_off_nx, active_nx;
  logic [15:0]           pitch_q [CHANNELS];
  logic [3:0]            rr;
  logic                  note_ok, hs, found, pick_off;
  logic [3:0]            pick;
  logic [15:0]           pick_pitch, pitch_in;
  logic [CHANNELS-1:0]   pend_any;

  assign note_ok           = (note <= 4'd11);
  assign pitch_in          = base_pitch(note) >> (2'd3 - octave);
  assign voice_write_valid = (state == ISSUE);
  assign hs                = voice_write_valid & voice_write_ready;
  assign pend_any          = pend_on | pend_off;
  assign busy              = (|pend_any) | voice_write_valid;

  // Round-robin pick: first pass from rr upward, second pass wraps from channel 0.
  always_comb begin
    found      = 1'b0;
    pick       = 4'd0;
    pick_off   = 1'b0;
    pick_pitch = 16'd0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && pend_any[i] && (4'(i) >= rr)) begin
        found = 1'b1; pick = 4'(i); pick_off = pend_off[i]; pick_pitch = pitch_q[i];
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && pend_any[i]) begin
        found = 1'b1; pick = 4'(i); pick_off = pend_off[i]; pick_pitch = pitch_q[i];
      end
    end
  end

  // Handshake retires pending work first; fresh key events then override it.
  always_comb begin
    pend_on_nx  = pend_on;
    pend_off_nx = pend_off;
    active_nx   = active;
    for (int i = 0; i < CHANNELS; i++) begin
      if (voice_ended[i] && active[i]) active_nx[i] = 1'b0;
      if (hs && (voice_channel == 4'(i))) begin
        if (voice_cmd == CMD_START) begin
          pend_on_nx[i] = 1'b0;
          active_nx[i]  = 1'b1;
        end else begin
          pend_off_nx[i] = 1'b0;
          active_nx[i]   = 1'b0;
        end
      end
      if (key_on[i] && note_ok) begin
        pend_on_nx[i]  = 1'b1;
        pend_off_nx[i] = RETRIG & active[i];
      end else if (key_off[i]) begin
        pend_off_nx[i] = 1'b1;
        pend_on_nx[i]  = 1'b0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = ISSUE;
      ISSUE:   if (voice_write_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_on         <= '0;
      pend_off        <= '0;
      active          <= '0;
      status_note_off <= '0;
      rr              <= 4'd0;
      voice_channel   <= 4'd0;
      voice_cmd       <= 2'b00;
      voice_pitch     <= 16'd0;
      for (int i = 0; i < CHANNELS; i++) pitch_q[i] <= 16'd0;
    end else begin
      pend_on         <= pend_on_nx;
      pend_off        <= pend_off_nx;
      active          <= active_nx;
      status_note_off <= active & ~active_nx;
      for (int i = 0; i < CHANNELS; i++) begin
        if (key_on[i] && note_ok) pitch_q[i] <= pitch_in;
      end
      if (state == IDLE && found) begin
        voice_channel <= pick;
        voice_cmd     <= pick_off ? CMD_STOP : CMD_START;
        voice_pitch   <= pick_off ? 16'd0 : pick_pitch;
      end
      if (hs) rr <= (voice_channel >= 4'(CHANNELS - 1)) ? 4'd0 : voice_channel + 4'd1;
    end
  end

endmodule

// File: tb/tb_midi_voice_scheduler.sv
// Scoreboarded random + directed bench for midi_voice_scheduler against a behavioural model.
module tb_midi_voice_scheduler;
  localparam int CH = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [CH-1:0] key_on = '0, key_off = '0, voice_ended = '0;
  logic [3:0]    note = 4'd0;
  logic [1:0]    octave = 2'd0;
  logic          ready = 1'b0;
  logic          voice_write_valid, busy;
  logic [3:0]    voice_channel;
  logic [1:0]    voice_cmd;
  logic [15:0]   voice_pitch;
  logic [CH-1:0] status_note_off;

  midi_voice_scheduler #(.CHANNELS(CH)) dut (
    .clk(clk), .reset_n(reset_n), .key_on(key_on), .key_off(key_off),
    .note(note), .octave(octave), .voice_write_valid(voice_write_valid),
    .voice_write_ready(ready), .voice_channel(voice_channel), .voice_cmd(voice_cmd),
    .voice_pitch(voice_pitch), .voice_ended(voice_ended),
    .status_note_off(status_note_off), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending/active sets per channel, one command outstanding at a time.
  typedef struct { int ch; int cmd; int pitch; } cmd_t;
  int            tbl [12] = '{4096, 4340, 4598, 4871, 5161, 5468, 5793, 6137, 6502, 6889, 7298, 7732};
  bit [CH-1:0]   m_on, m_off, m_act, m_status;
  int            m_pitch [CH];
  int            m_rr;
  bit            m_valid;
  cmd_t          m_cur;
  cmd_t          exp_q[$];
`ifdef MIDI_VOICE_SCHEDULER_RETRIGGER_EN
  bit            m_retrig = 1'b1;
`else
  bit            m_retrig = 1'b0;
`endif

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_on = '0; m_off = '0; m_act = '0; m_status = '0;
      m_rr = 0; m_valid = 1'b0;
      for (int i = 0; i < CH; i++) m_pitch[i] = 0;
      exp_q.delete();
    end else begin
      bit [CH-1:0] old_act;
      old_act = m_act;
      m_act   = m_act & ~voice_ended;
      if (m_valid) begin
        if (ready) begin
          if (m_cur.cmd == 1) begin m_on[m_cur.ch] = 1'b0; m_act[m_cur.ch] = 1'b1; end
          else                begin m_off[m_cur.ch] = 1'b0; m_act[m_cur.ch] = 1'b0; end
          m_rr    = (m_cur.ch + 1) % CH;
          m_valid = 1'b0;
        end
      end else begin
        for (int k = 0; k < CH; k++) begin
          int c;
          c = (m_rr + k) % CH;
          if (!m_valid && (m_on[c] || m_off[c])) begin
            m_cur.ch    = c;
            m_cur.cmd   = m_off[c] ? 2 : 1;
            m_cur.pitch = m_off[c] ? 0 : m_pitch[c];
            exp_q.push_back(m_cur);
            m_valid = 1'b1;
          end
        end
      end
      for (int i = 0; i < CH; i++) begin
        if (key_on[i] && note <= 11) begin
          m_on[i]    = 1'b1;
          m_off[i]   = m_retrig && old_act[i];
          m_pitch[i] = tbl[note] / (1 << (3 - octave));
        end else if (key_off[i]) begin
          m_off[i] = 1'b1;
          m_on[i]  = 1'b0;
        end
      end
      m_status = old_act & ~m_act;
    end
  end

  always @(negedge clk) begin
    chk("valid", int'(voice_write_valid), int'(m_valid));
    chk("busy", int'(busy), int'((|m_on) | (|m_off) | m_valid));
    chk("status_note_off", int'(status_note_off), int'(m_status));
    if (voice_write_valid) begin
      chk("cmd_queue", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        chk("channel", int'(voice_channel), exp_q[0].ch);
        chk("cmd", int'(voice_cmd), exp_q[0].cmd);
        chk("pitch", int'(voice_pitch), exp_q[0].pitch);
        if (ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic pulse_on(input logic [CH-1:0] m, input int n, input int o);
    key_on = m; note = 4'(n); octave = 2'(o);
    tick();
    key_on = '0;
  endtask

  task automatic wait_valid();
    for (int t = 0; t < 30 && !voice_write_valid; t++) tick();
    chk("wait_valid", int'(voice_write_valid), 1);
  endtask

  initial begin
    tick(2);
    chk("rst_valid", int'(voice_write_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pitch", int'(voice_pitch), 0);
    chk("rst_cmd", int'(voice_cmd), 0);
    reset_n = 1'b1;
    tick(3);

    // First-command latency and pitch of A in octave 3.
    ready = 1'b1;
    pulse_on(3'b001, 9, 3);
    chk("t1_not_yet", int'(voice_write_valid), 0);
    tick();
    chk("t1_valid", int'(voice_write_valid), 1);
    chk("t1_pitch", int'(voice_pitch), 6889);
    chk("t1_cmd", int'(voice_cmd), 1);
    tick();
    chk("t1_busy_after", int'(busy), 0);

    // Low octave pitch, then voice_ended produces one note-off pulse.
    pulse_on(3'b010, 0, 1);
    wait_valid();
    chk("t2_pitch", int'(voice_pitch), 1024);
    chk("t2_chan", int'(voice_channel), 1);
    tick(2);
    voice_ended = 3'b010;
    tick();
    voice_ended = '0;
    chk("t2_note_off", int'(status_note_off), 2);
    tick();
    chk("t2_note_off_end", int'(status_note_off), 0);

    // Stalled port with three simultaneous starts: round robin from channel 0.
    do_reset();
    ready = 1'b0;
    pulse_on(3'b111, 4, 2);
    wait_valid();
    tick(5);
    chk("t3_stall_chan", int'(voice_channel), 0);
    ready = 1'b1;
    for (int c = 0; c < CH; c++) begin
      wait_valid();
      chk("t3_order", int'(voice_channel), c);
      tick();
    end

    // key_on and key_off together: key_on wins.
    do_reset();
    key_off = 3'b100;
    pulse_on(3'b100, 2, 0);
    key_off = '0;
    wait_valid();
    chk("t4_chan", int'(voice_channel), 2);
    chk("t4_cmd", int'(voice_cmd), 1);
    tick(3);

    // Invalid note is ignored.
    pulse_on(3'b001, 13, 2);
    tick(2);
    chk("t5_busy", int'(busy), 0);

    // Key_on on an active voice.
    pulse_on(3'b001, 5, 3);
    wait_valid();
    tick(2);
    pulse_on(3'b001, 7, 3);
    wait_valid();
    chk("t6_first_cmd", int'(voice_cmd), m_retrig ? 2 : 1);
    tick(4);

    // Reset in the middle of a stalled command.
    ready = 1'b0;
    pulse_on(3'b010, 3, 2);
    wait_valid();
    #2 reset_n = 1'b0;
    #1 chk("t7_async_valid", int'(voice_write_valid), 0);
    chk("t7_async_busy", int'(busy), 0);
    tick(2);
    reset_n = 1'b1;
    ready = 1'b1;
    tick(10);

    // Random traffic checked by the scoreboard.
    for (int n = 0; n < 3000; n++) begin
      key_on      = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
      key_off     = ($urandom_range(0, 4) == 0) ? CH'($urandom) : '0;
      voice_ended = ($urandom_range(0, 5) == 0) ? CH'($urandom) : '0;
      note        = 4'($urandom_range(0, 15));
      octave      = 2'($urandom);
      ready       = ($urandom_range(0, 2) != 0);
      tick();
    end
    key_on = '0; key_off = '0; voice_ended = '0; ready = 1'b1;
    tick(40);
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
